hazard_scoreboard: RTL and testbench

Parametrised scoreboard hazard unit for the pipelined RISC-V core, sitting beside the decode stage. It generalises single-cycle load-to-use detection to any number of outstanding long-latency writers: loads with variable memory latency and multi-cycle ALU ops. It tracks a per-register busy bit and an outstanding-op count, and stalls decode on RAW, WAW or capacity hazards. It also keeps a saturating stall-cycle counter and a sticky stall-timeout flag for debug.

---
 rtl/hazard_if.sv | 31 +++
 rtl/hazard_scoreboard.sv | 94 +++++++++
 tb/tb_hazard_scoreboard.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Decode/completion bundle between the decode stage and the hazard scoreboard.
// Handshake: decode_valid qualifies the decode fields; stall=1 means the instruction is held (not accepted) this cycle.
interface hazard_if #(
    parameter int REG_W = 5
);
    logic             decode_valid;
    logic [REG_W-1:0] decode_sel_rs1;
    logic [REG_W-1:0] decode_sel_rs2;
    logic             decode_uses_rs1;
    logic             decode_uses_rs2;
    logic [REG_W-1:0] decode_sel_rd;
    logic             decode_long_op;
    logic             flush;
    logic             complete_valid;
    logic [REG_W-1:0] complete_sel_rd;
    logic             stall;

    modport master (
        output decode_valid, decode_sel_rs1, decode_sel_rs2, decode_uses_rs1,
               decode_uses_rs2, decode_sel_rd, decode_long_op, flush,
               complete_valid, complete_sel_rd,
        input  stall
    );

    modport slave (
        input  decode_valid, decode_sel_rs1, decode_sel_rs2, decode_uses_rs1,
               decode_uses_rs2, decode_sel_rd, decode_long_op, flush,
               complete_valid, complete_sel_rd,
        output stall
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Scoreboard hazard unit: per-register busy bits for outstanding long-latency
// writers, RAW/WAW/capacity stall generation, and stall debug counters.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_W       = 5,
    parameter int MAX_PENDING = 4,
    parameter int BYPASS_WB   = 1,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 256
) (
    input  logic                               clk,
    input  logic                               rst,
    hazard_if.slave                            bus,
    output logic [NUM_REGS-1:0]                busy_vec,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
    output logic [CNT_W-1:0]                   stall_cycles,
    output logic                               hazard_timeout
);
    localparam int PC_W  = $clog2(MAX_PENDING+1);
    localparam int RUN_W = $clog2(TIMEOUT+1);

    logic [NUM_REGS-1:0] eff_busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [RUN_W-1:0]    run_cnt;
    logic                comp_hit;
    logic                raw_hit;
    logic                waw_hit;
    logic                cap_hit;
    logic                stall_int;
    logic                issue;
    logic                rd_nonzero;

    // A writeback this cycle hides its busy bit from decode when forwarding exists.
    always_comb begin
        eff_busy = busy_vec;
        if ((BYPASS_WB != 0) && bus.complete_valid && (bus.complete_sel_rd != REG_W'(0)))
            eff_busy[bus.complete_sel_rd] = 1'b0;
    end

    // Only a completion that actually retires a tracked writer frees a slot.
    assign comp_hit   = bus.complete_valid && (bus.complete_sel_rd != REG_W'(0)) &&
                        busy_vec[bus.complete_sel_rd];
    assign rd_nonzero = bus.decode_sel_rd != REG_W'(0);
    assign raw_hit    = (bus.decode_uses_rs1 && eff_busy[bus.decode_sel_rs1]) ||
                        (bus.decode_uses_rs2 && eff_busy[bus.decode_sel_rs2]);
    assign waw_hit    = bus.decode_long_op && rd_nonzero && eff_busy[bus.decode_sel_rd];
    assign cap_hit    = bus.decode_long_op && rd_nonzero &&
                        (pending_count == PC_W'(MAX_PENDING)) && !comp_hit;
    assign stall_int  = bus.decode_valid && !bus.flush && (raw_hit || waw_hit || cap_hit);
    assign issue      = bus.decode_valid && !bus.flush && !stall_int &&
                        bus.decode_long_op && rd_nonzero;
    assign bus.stall  = stall_int;

    // Clear before set so a same-register issue/complete pair leaves the bit set.
    always_comb begin
        busy_next = busy_vec;
        if (comp_hit)
            busy_next[bus.complete_sel_rd] = 1'b0;
        if (issue)
            busy_next[bus.decode_sel_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_vec      <= '0;
            pending_count <= '0;
        end else begin
            busy_vec <= busy_next;
            case ({issue, comp_hit})
                2'b10:   pending_count <= pending_count + PC_W'(1);
                2'b01:   pending_count <= pending_count - PC_W'(1);
                default: pending_count <= pending_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles   <= '0;
            run_cnt        <= '0;
            hazard_timeout <= 1'b0;
        end else begin
            if (stall_int && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (!stall_int)
                run_cnt <= '0;
            else if (run_cnt != RUN_W'(TIMEOUT))
                run_cnt <= run_cnt + RUN_W'(1);
            if (stall_int && (run_cnt == RUN_W'(TIMEOUT-1)))
                hazard_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus randomized traffic
// checked against a queue-of-pending-writers reference model.
module tb_hazard_scoreboard;
  localparam int NR   = 32;
  localparam int RW   = 5;
  localparam int MAXP = 4;
  localparam int BYP  = 1;
  localparam int CW   = 32;
  localparam int TMO  = 8;
  localparam int PCW  = $clog2(MAXP+1);

  logic clk = 1'b0;
  logic rst;
  logic [NR-1:0]  busy_vec;
  logic [PCW-1:0] pending_count;
  logic [CW-1:0]  stall_cycles;
  logic           hazard_timeout;

  hazard_if #(.REG_W(RW)) bus ();

  hazard_scoreboard #(
    .NUM_REGS(NR), .REG_W(RW), .MAX_PENDING(MAXP), .BYPASS_WB(BYP),
    .CNT_W(CW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy_vec(busy_vec),
    .pending_count(pending_count), .stall_cycles(stall_cycles),
    .hazard_timeout(hazard_timeout)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model: list of registers with an outstanding writer
  int    pend_q[$];
  longint m_sc = 0;
  int    m_run = 0;
  bit    m_tmo = 1'b0;
  logic [NR-1:0] exp_q[$];

  function automatic bit in_q(int r);
    foreach (pend_q[i]) if (pend_q[i] == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit eff(int r);
    return in_q(r) && !(BYP != 0 && bus.complete_valid && int'(bus.complete_sel_rd) == r && r != 0);
  endfunction

  function automatic bit m_freeing();
    return bus.complete_valid && bus.complete_sel_rd != 0 && in_q(int'(bus.complete_sel_rd));
  endfunction

  function automatic bit m_stall();
    int rd = int'(bus.decode_sel_rd);
    bit raw, waw, cap;
    raw = (bus.decode_uses_rs1 && eff(int'(bus.decode_sel_rs1))) ||
          (bus.decode_uses_rs2 && eff(int'(bus.decode_sel_rs2)));
    waw = bus.decode_long_op && rd != 0 && eff(rd);
    cap = bus.decode_long_op && rd != 0 && pend_q.size() == MAXP && !m_freeing();
    return bus.decode_valid && !bus.flush && (raw || waw || cap);
  endfunction

  function automatic logic [NR-1:0] m_busy_vec();
    logic [NR-1:0] v = '0;
    foreach (pend_q[i]) v[pend_q[i]] = 1'b1;
    return v;
  endfunction

  function automatic void m_advance();
    bit s = m_stall();
    bit iss;
    int rd = int'(bus.decode_sel_rd);
    if (rst) begin
      pend_q.delete(); m_sc = 0; m_run = 0; m_tmo = 1'b0;
      return;
    end
    iss = bus.decode_valid && !bus.flush && !s && bus.decode_long_op && rd != 0;
    if (m_freeing())
      foreach (pend_q[i]) if (pend_q[i] == int'(bus.complete_sel_rd)) begin pend_q.delete(i); break; end
    if (iss) pend_q.push_back(rd);
    if (s) begin
      if (m_sc < (64'd1 << CW) - 1) m_sc++;
      m_run++;
      if (m_run >= TMO) m_tmo = 1'b1;
    end else m_run = 0;
  endfunction

  // driver tasks
  task automatic drive(input bit dv, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit lo, input bit fl, input bit cv, input int crd);
    bus.decode_valid = dv; bus.decode_sel_rs1 = RW'(r1); bus.decode_uses_rs1 = u1;
    bus.decode_sel_rs2 = RW'(r2); bus.decode_uses_rs2 = u2; bus.decode_sel_rd = RW'(rd);
    bus.decode_long_op = lo; bus.flush = fl; bus.complete_valid = cv; bus.complete_sel_rd = RW'(crd);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    #1;
    m_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); tick(); rst = 1'b0; #1;
    n_cmp++; if (busy_vec !== '0) begin n_fail++; $display("FAIL reset_busy: got %h exp 0", busy_vec); end
    n_cmp++; if (pending_count !== '0) begin n_fail++; $display("FAIL reset_pending: got %0d exp 0", pending_count); end
    n_cmp++; if (stall_cycles !== '0) begin n_fail++; $display("FAIL reset_stall_cycles: got %0d exp 0", stall_cycles); end
    n_cmp++; if (hazard_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b exp 0", hazard_timeout); end
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", bus.stall); end
  endtask

  task automatic test_load_use();
    longint sc0 = m_sc;
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0); tick();
    n_cmp++; if (busy_vec !== 32'h20) begin n_fail++; $display("FAIL lu_busy: got %h exp 20", busy_vec); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0); #1;
      n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall_%0d: got %b exp 1", i, bus.stall); end
      tick();
    end
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 5); #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL lu_bypass: got %b exp 0", bus.stall); end
    tick();
    n_cmp++; if (stall_cycles !== CW'(sc0 + 3)) begin n_fail++; $display("FAIL lu_cycles: got %0d exp %0d", stall_cycles, sc0 + 3); end
    n_cmp++; if (pending_count !== '0) begin n_fail++; $display("FAIL lu_pending: got %0d exp 0", pending_count); end
  endtask

  task automatic test_x0_unused();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0); tick();
    n_cmp++; if (pending_count !== '0 || busy_vec !== '0) begin n_fail++; $display("FAIL x0_issue: got %0d/%h exp 0/0", pending_count, busy_vec); end
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0); tick();
    drive(1, 0, 1, 9, 0, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL unused_rs2: got %b exp 0", bus.stall); end
    drive(1, 0, 1, 9, 1, 0, 0, 0, 0, 0); #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL used_rs2: got %b exp 1", bus.stall); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9); tick();
    n_cmp++; if (pending_count !== '0) begin n_fail++; $display("FAIL spurious_complete: got %0d exp 0", pending_count); end
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin drive(1, 0, 0, 0, 0, r, 1, 0, 0, 0); tick(); end
    n_cmp++; if (pending_count !== PCW'(4)) begin n_fail++; $display("FAIL cap_full: got %0d exp 4", pending_count); end
    drive(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL cap_stall: got %b exp 1", bus.stall); end
    drive(1, 0, 0, 0, 0, 6, 1, 0, 1, 2); #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL cap_free: got %b exp 0", bus.stall); end
    tick();
    n_cmp++; if (pending_count !== PCW'(4) || busy_vec !== 32'h5A) begin n_fail++; $display("FAIL cap_swap: got %0d/%h exp 4/5a", pending_count, busy_vec); end
    foreach (exp_q[i]) exp_q.delete(i);
    for (int r = 1; r <= 6; r++) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 1, r); tick(); end
    n_cmp++; if (pending_count !== '0) begin n_fail++; $display("FAIL cap_drain: got %0d exp 0", pending_count); end
  endtask

  task automatic test_waw_same_cycle();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); #1;
    n_cmp++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL waw_stall: got %b exp 1", bus.stall); end
    tick();
    drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 7); #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL waw_release: got %b exp 0", bus.stall); end
    tick();
    n_cmp++; if (busy_vec !== 32'h80 || pending_count !== PCW'(1)) begin n_fail++; $display("FAIL waw_same: got %h/%0d exp 80/1", busy_vec, pending_count); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7); tick();
  endtask

  task automatic test_flush_reset();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    drive(1, 3, 1, 0, 0, 8, 1, 1, 0, 0); #1;
    n_cmp++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b exp 0", bus.stall); end
    tick();
    n_cmp++; if (busy_vec !== 32'h8) begin n_fail++; $display("FAIL flush_noissue: got %h exp 8", busy_vec); end
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 0); tick();
    n_cmp++; if (pending_count !== PCW'(3)) begin n_fail++; $display("FAIL pre_reset: got %0d exp 3", pending_count); end
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (busy_vec !== '0 || pending_count !== '0 || stall_cycles !== '0) begin n_fail++; $display("FAIL mid_reset: got %h/%0d/%0d exp 0/0/0", busy_vec, pending_count, stall_cycles); end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 10); tick();
    n_cmp++; if (busy_vec !== '0 || pending_count !== '0) begin n_fail++; $display("FAIL post_reset_complete: got %h/%0d exp 0/0", busy_vec, pending_count); end
  endtask

  task automatic test_timeout();
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 0); tick();
    for (int i = 1; i <= TMO; i++) begin
      drive(1, 12, 1, 0, 0, 0, 0, 0, 0, 0); tick();
      n_cmp++; if (hazard_timeout !== (i == TMO)) begin n_fail++; $display("FAIL timeout_%0d: got %b exp %b", i, hazard_timeout, i == TMO); end
    end
    drive(1, 12, 1, 0, 0, 0, 0, 0, 1, 12); tick();
    idle(); tick();
    n_cmp++; if (hazard_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b exp 1", hazard_timeout); end
  endtask

  task automatic test_random();
    bit exp_s;
    logic [NR-1:0] exp_b;
    for (int c = 0; c < 600; c++) begin
      bit cv = 1'b0;
      int crd = 0;
      if (pend_q.size() > 0 && $urandom_range(0, 2) == 0) begin
        cv = 1'b1; crd = pend_q[$urandom_range(0, pend_q.size() - 1)];
      end else if ($urandom_range(0, 9) == 0) begin
        cv = 1'b1; crd = $urandom_range(0, 7);
      end
      rst = ($urandom_range(0, 79) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 1), $urandom_range(0, 9) == 0, cv, crd);
      #1;
      exp_s = m_stall();
      n_cmp++; if (bus.stall !== exp_s) begin n_fail++; $display("FAIL rnd_stall c%0d: got %b exp %b", c, bus.stall, exp_s); end
      tick();
      exp_b = m_busy_vec();
      exp_q.push_back(exp_b);
      n_cmp++; if (busy_vec !== exp_q.pop_front()) begin n_fail++; $display("FAIL rnd_busy c%0d: got %h exp %h", c, busy_vec, exp_b); end
      n_cmp++; if (pending_count !== PCW'(pend_q.size())) begin n_fail++; $display("FAIL rnd_pending c%0d: got %0d exp %0d", c, pending_count, pend_q.size()); end
      n_cmp++; if (stall_cycles !== CW'(m_sc)) begin n_fail++; $display("FAIL rnd_cycles c%0d: got %0d exp %0d", c, stall_cycles, m_sc); end
      n_cmp++; if (hazard_timeout !== m_tmo) begin n_fail++; $display("FAIL rnd_timeout c%0d: got %b exp %b", c, hazard_timeout, m_tmo); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_x0_unused();
    test_capacity();
    test_waw_same_cycle();
    test_flush_reset();
    test_timeout();
    test_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
